iob_ila_readout_ctrl: RTL and testbench



---
 rtl/iob_ila_readout_pkg.sv | 40 ++++
 rtl/iob_ila_readout_master.sv | 94 +++++++++
 rtl/iob_ila_readout_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_iob_ila_readout_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_ila_readout_pkg.sv
// Shared types, default ILA register addresses and width helpers
// for the ILA readout controller.
package iob_ila_readout_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_NS,
    S_WAIT_NS,
    S_WR_IDX,
    S_WR_SEL,
    S_RD_DATA,
    S_WAIT_DATA,
    S_PUSH,
    S_DONE
  } rd_state_t;

  typedef enum logic [1:0] {
    M_IDLE,
    M_REQ,
    M_WAIT
  } mst_state_t;

  localparam logic [4:0] DEF_N_SAMPLES_ADDR = 5'h10;
  localparam logic [4:0] DEF_INDEX_ADDR     = 5'h04;
  localparam logic [4:0] DEF_SEL_ADDR       = 5'h08;
  localparam logic [4:0] DEF_DATA_ADDR      = 5'h0C;

  // Bus words per sampled signal, never below one.
  function automatic int words_f(input int sig_w, input int data_w);
    int w;
    w = (sig_w + data_w - 1) / data_w;
    return (w < 1) ? 1 : w;
  endfunction

  // Signal-select width, matching the ILA select register.
  function automatic int sel_w_f(input int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/iob_ila_readout_master.sv
// Single-outstanding IOb request engine: issues one request,
// holds it until accepted, then waits for read data if needed.
module iob_ila_readout_master
  import iob_ila_readout_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_iob_valid,
  output logic [ADDR_W-1:0] o_iob_addr,
  output logic [DATA_W-1:0] o_iob_wdata,
  output logic [DATA_W/8-1:0] o_iob_wstrb,
  input  logic              i_iob_ready,
  input  logic              i_iob_rvalid,
  input  logic [DATA_W-1:0] i_iob_rdata
);

  localparam int STRB_W = DATA_W / 8;

  mst_state_t          r_state;
  mst_state_t          w_next;
  logic                r_valid;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;

  assign o_iob_valid = r_valid;
  assign o_iob_addr  = r_addr;
  assign o_iob_wdata = r_wdata;
  assign o_iob_wstrb = r_wstrb;
  assign o_rdata     = i_iob_rdata;

  // Next state and completion: writes finish on accept,
  // reads on the first rvalid at or after accept.
  always_comb begin
    w_next = r_state;
    o_done = 1'b0;
    unique case (r_state)
      M_IDLE: begin
        if (i_req) w_next = M_REQ;
      end
      M_REQ: begin
        if (i_iob_ready) begin
          if (r_we || i_iob_rvalid) begin
            w_next = M_IDLE;
            o_done = 1'b1;
          end else begin
            w_next = M_WAIT;
          end
        end
      end
      M_WAIT: begin
        if (i_iob_rvalid) begin
          w_next = M_IDLE;
          o_done = 1'b1;
        end
      end
      default: w_next = M_IDLE;
    endcase
  end

  // Request registers: captured on issue, held until accepted.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= M_IDLE;
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == M_IDLE && i_req) begin
        r_valid <= 1'b1;
        r_we    <= i_we;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
        r_wstrb <= {STRB_W{i_we}};
      end else if (r_state == M_REQ && i_iob_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/iob_ila_readout_ctrl.sv
// ILA readout controller: drains the sample buffer through the
// ILA register slave and streams every sample word out.
module iob_ila_readout_ctrl
  import iob_ila_readout_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int SIGNAL_W = 32,
  parameter int BUFFER_W = 10,
  parameter logic [ADDR_W-1:0] N_SAMPLES_ADDR = ADDR_W'(DEF_N_SAMPLES_ADDR),
  parameter logic [ADDR_W-1:0] INDEX_ADDR     = ADDR_W'(DEF_INDEX_ADDR),
  parameter logic [ADDR_W-1:0] SEL_ADDR       = ADDR_W'(DEF_SEL_ADDR),
  parameter logic [ADDR_W-1:0] DATA_ADDR      = ADDR_W'(DEF_DATA_ADDR)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  input  logic                abort_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [BUFFER_W-1:0] count_o,
  output logic                iob_valid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_ready_i,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  output logic [DATA_W-1:0]   tdata_o,
  output logic                tvalid_o,
  input  logic                tready_i,
  output logic                tlast_o
);

  localparam int WORDS = words_f(SIGNAL_W, DATA_W);
  localparam int SEL_W = sel_w_f(WORDS);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(WORDS - 1);

  rd_state_t           r_state;
  rd_state_t           w_next;
  logic [BUFFER_W-1:0] r_count;
  logic [BUFFER_W-1:0] w_count;
  logic [BUFFER_W-1:0] r_idx;
  logic [BUFFER_W-1:0] w_idx;
  logic [SEL_W-1:0]    r_sel;
  logic [SEL_W-1:0]    w_sel;
  logic [DATA_W-1:0]   r_tdata;
  logic [DATA_W-1:0]   w_tdata;
  logic                r_abort;
  logic                w_abort_n;
  logic                r_issued;
  logic                w_issued;

  logic                w_abort;
  logic                w_last_idx;
  logic                w_last_sel;
  logic                w_req;
  logic                w_we;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_mdone;
  logic [DATA_W-1:0]   w_mrdata;

  assign w_abort    = r_abort | abort_i;
  assign w_last_idx = (r_idx == r_count - BUFFER_W'(1));
  assign w_last_sel = (r_sel == LAST_SEL);

  assign busy_o   = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done_o   = (r_state == S_DONE);
  assign count_o  = r_count;
  assign tdata_o  = r_tdata;
  assign tvalid_o = (r_state == S_PUSH);
  assign tlast_o  = tvalid_o && w_last_idx && w_last_sel;

  iob_ila_readout_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_master (
    .i_clk        (clk_i),
    .i_rst_n      (rst_n_i),
    .i_req        (w_req),
    .i_we         (w_we),
    .i_addr       (w_addr),
    .i_wdata      (w_wdata),
    .o_done       (w_mdone),
    .o_rdata      (w_mrdata),
    .o_iob_valid  (iob_valid_o),
    .o_iob_addr   (iob_addr_o),
    .o_iob_wdata  (iob_wdata_o),
    .o_iob_wstrb  (iob_wstrb_o),
    .i_iob_ready  (iob_ready_i),
    .i_iob_rvalid (iob_rvalid_i),
    .i_iob_rdata  (iob_rdata_i)
  );

  // Sequencer: next state, bus op selection and counter updates.
  // An abort lets any issued transaction finish before DONE.
  always_comb begin
    w_next    = r_state;
    w_count   = r_count;
    w_idx     = r_idx;
    w_sel     = r_sel;
    w_tdata   = r_tdata;
    w_issued  = r_issued;
    w_abort_n = r_abort;
    w_req     = 1'b0;
    w_we      = 1'b0;
    w_addr    = '0;
    w_wdata   = '0;
    if (r_state == S_IDLE || r_state == S_DONE) begin
      w_abort_n = 1'b0;
    end else if (abort_i) begin
      w_abort_n = 1'b1;
    end
    unique case (r_state)
      S_IDLE: begin
        if (start_i) w_next = S_RD_NS;
      end
      S_RD_NS: begin
        if (w_abort) begin
          w_next = S_DONE;
        end else begin
          w_req  = 1'b1;
          w_addr = N_SAMPLES_ADDR;
          w_next = S_WAIT_NS;
        end
      end
      S_WAIT_NS: begin
        if (w_mdone) begin
          if (w_abort) begin
            w_next = S_DONE;
          end else begin
            w_count = w_mrdata[BUFFER_W-1:0];
            w_idx   = '0;
            w_sel   = '0;
            w_next  = (w_mrdata[BUFFER_W-1:0] == '0) ? S_DONE : S_WR_IDX;
          end
        end
      end
      S_WR_IDX: begin
        w_we    = 1'b1;
        w_addr  = INDEX_ADDR;
        w_wdata = DATA_W'(r_idx);
        if (!r_issued) begin
          if (w_abort) begin
            w_next = S_DONE;
          end else begin
            w_req    = 1'b1;
            w_issued = 1'b1;
          end
        end else if (w_mdone) begin
          w_issued = 1'b0;
          w_next   = w_abort ? S_DONE : S_WR_SEL;
        end
      end
      S_WR_SEL: begin
        w_we    = 1'b1;
        w_addr  = SEL_ADDR;
        w_wdata = DATA_W'(r_sel);
        if (!r_issued) begin
          if (w_abort) begin
            w_next = S_DONE;
          end else begin
            w_req    = 1'b1;
            w_issued = 1'b1;
          end
        end else if (w_mdone) begin
          w_issued = 1'b0;
          w_next   = w_abort ? S_DONE : S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (w_abort) begin
          w_next = S_DONE;
        end else begin
          w_req  = 1'b1;
          w_addr = DATA_ADDR;
          w_next = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        if (w_mdone) begin
          if (w_abort) begin
            w_next = S_DONE;
          end else begin
            w_tdata = w_mrdata;
            w_next  = S_PUSH;
          end
        end
      end
      S_PUSH: begin
        if (tready_i) begin
          if (w_abort) begin
            w_next = S_DONE;
          end else if (!w_last_sel) begin
            w_sel  = r_sel + SEL_W'(1);
            w_next = S_WR_SEL;
          end else if (!w_last_idx) begin
            w_idx  = r_idx + BUFFER_W'(1);
            w_sel  = '0;
            w_next = S_WR_IDX;
          end else begin
            w_next = S_DONE;
          end
        end else if (w_abort) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_idx    <= '0;
      r_sel    <= '0;
      r_tdata  <= '0;
      r_abort  <= 1'b0;
      r_issued <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_count  <= w_count;
      r_idx    <= w_idx;
      r_sel    <= w_sel;
      r_tdata  <= w_tdata;
      r_abort  <= w_abort_n;
      r_issued <= w_issued;
    end
  end

endmodule

// File: tb/tb_iob_ila_readout_ctrl.sv
// Testbench for iob_ila_readout_ctrl: ILA register slave model,
// stream scoreboard and directed run scenarios.
module tb_iob_ila_readout_ctrl;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int SIGNAL_W = 64;
  localparam int BUFFER_W = 10;
  localparam int WORDS    = 2;

  logic                clk = 1'b0;
  logic                rst_n_i = 1'b0;
  logic                start_i = 1'b0;
  logic                abort_i = 1'b0;
  logic                busy_o;
  logic                done_o;
  logic [BUFFER_W-1:0] count_o;
  logic                iob_valid_o;
  logic [ADDR_W-1:0]   iob_addr_o;
  logic [DATA_W-1:0]   iob_wdata_o;
  logic [DATA_W/8-1:0] iob_wstrb_o;
  logic                iob_ready_i = 1'b0;
  logic                iob_rvalid_i = 1'b0;
  logic [DATA_W-1:0]   iob_rdata_i = '0;
  logic [DATA_W-1:0]   tdata_o;
  logic                tvalid_o;
  logic                tready_i = 1'b0;
  logic                tlast_o;

  iob_ila_readout_ctrl #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .SIGNAL_W (SIGNAL_W),
    .BUFFER_W (BUFFER_W)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .count_o      (count_o),
    .iob_valid_o  (iob_valid_o),
    .iob_addr_o   (iob_addr_o),
    .iob_wdata_o  (iob_wdata_o),
    .iob_wstrb_o  (iob_wstrb_o),
    .iob_ready_i  (iob_ready_i),
    .iob_rvalid_i (iob_rvalid_i),
    .iob_rdata_i  (iob_rdata_i),
    .tdata_o      (tdata_o),
    .tvalid_o     (tvalid_o),
    .tready_i     (tready_i),
    .tlast_o      (tlast_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] sample(input logic [31:0] i,
                                         input logic [31:0] s);
    return 32'hA0 + i + (s << 8);
  endfunction

  // ILA register slave model state.
  logic [31:0] ns_reg = '0;
  int          rdy_dly = 0;
  int          rv_dly = 1;
  bit          rnd_rdy = 1'b0;
  bit          hold = 1'b0;
  int          hwait = 0;
  logic [ADDR_W-1:0]   h_addr;
  logic [DATA_W-1:0]   h_wdata;
  logic [DATA_W/8-1:0] h_wstrb;
  bit          rd_pend = 1'b0;
  bit          rd_is_data = 1'b0;
  int          rv_cnt = 0;
  logic [31:0] rd_val = '0;
  logic [31:0] reg_idx = '0;
  logic [31:0] reg_sel = '0;
  int          n_data_rd = 0;
  int          data_rv_cyc = -1;
  logic [31:0] idx_log[$];
  logic [31:0] sel_log[$];
  bit          is_rd;
  bit          is_data;
  logic [31:0] v;

  // Slave: decides ready/rvalid for the coming edge, logs writes,
  // checks request stability and single-outstanding behaviour.
  always @(negedge clk) begin
    iob_ready_i  = 1'b0;
    iob_rvalid_i = 1'b0;
    if (!rst_n_i) begin
      hold    = 1'b0;
      hwait   = 0;
      rd_pend = 1'b0;
      rv_cnt  = 0;
    end else begin
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          iob_rvalid_i = 1'b1;
          iob_rdata_i  = rd_val;
          rd_pend      = 1'b0;
          if (rd_is_data) data_rv_cyc = cyc;
        end
      end
      if (iob_valid_o) begin
        if (!hold) begin
          hold    = 1'b1;
          hwait   = 0;
          h_addr  = iob_addr_o;
          h_wdata = iob_wdata_o;
          h_wstrb = iob_wstrb_o;
        end else begin
          check("req_stable", {iob_addr_o, iob_wdata_o, iob_wstrb_o},
                {h_addr, h_wdata, h_wstrb});
        end
        if (hwait >= rdy_dly) begin
          iob_ready_i = 1'b1;
          hold        = 1'b0;
          check("one_outstanding", rd_pend, 0);
          is_rd   = 1'b0;
          is_data = 1'b0;
          v       = '0;
          case (iob_addr_o)
            5'h04: begin
              check("idx_wstrb", iob_wstrb_o, 4'hF);
              idx_log.push_back(iob_wdata_o);
              reg_idx = iob_wdata_o;
            end
            5'h08: begin
              check("sel_wstrb", iob_wstrb_o, 4'hF);
              sel_log.push_back(iob_wdata_o);
              reg_sel = iob_wdata_o;
            end
            5'h10: begin
              check("ns_rd_wstrb", iob_wstrb_o, 0);
              is_rd = 1'b1;
              v     = ns_reg;
            end
            5'h0C: begin
              check("data_rd_wstrb", iob_wstrb_o, 0);
              is_rd   = 1'b1;
              is_data = 1'b1;
              v       = sample(reg_idx, reg_sel);
              n_data_rd++;
            end
            default: begin
              n_vec++;
              n_err++;
              $display("FAIL bus_addr: got %0h required 04/08/0C/10",
                       iob_addr_o);
            end
          endcase
          if (is_rd) begin
            rd_val     = v;
            rd_is_data = is_data;
            rd_pend    = 1'b1;
            if (rv_dly == 0) begin
              iob_rvalid_i = 1'b1;
              iob_rdata_i  = v;
              rd_pend      = 1'b0;
              if (is_data) data_rv_cyc = cyc;
            end else begin
              rv_cnt = rv_dly;
            end
          end
        end else begin
          hwait++;
        end
      end
    end
  end

  // Stream scoreboard: expected beats come from the run model.
  logic [32:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [32:0] e;
  bit          stall = 1'b0;
  logic [31:0] st_data;
  int          n_done = 0;

  always @(negedge clk) begin
    if (!rst_n_i) begin
      tready_i = 1'b0;
      stall    = 1'b0;
    end else begin
      if (tvalid_o && iob_valid_o) check("bus_while_stream", 1, 0);
      if (stall && tvalid_o) check("tdata_stall", tdata_o, st_data);
      if (tlast_o && !tvalid_o) check("tlast_no_valid", 1, 0);
      tready_i = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tvalid_o) begin
        if (tready_i) begin
          stall = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", tdata_o, 33'h1_0000_0000);
          end else begin
            e = exp_q.pop_front();
            check("tdata", tdata_o, e[31:0]);
            check("tlast", tlast_o, e[32]);
          end
          got_q.push_back(tdata_o);
        end else begin
          stall   = 1'b1;
          st_data = tdata_o;
        end
      end else begin
        stall = 1'b0;
      end
      if (done_o) n_done++;
    end
  end

  int t0 = 0;
  int lat = 0;
  int done_c = 0;

  task automatic prep(input logic [31:0] ns, input int rdl,
                      input int rvl, input bit rnd, input bit beats);
    int cnt;
    cnt     = int'(ns[BUFFER_W-1:0]);
    ns_reg  = ns;
    rdy_dly = rdl;
    rv_dly  = rvl;
    rnd_rdy = rnd;
    exp_q.delete();
    got_q.delete();
    idx_log.delete();
    sel_log.delete();
    n_done      = 0;
    n_data_rd   = 0;
    data_rv_cyc = -1;
    if (beats) begin
      for (int i = 0; i < cnt; i++) begin
        for (int s = 0; s < WORDS; s++) begin
          exp_q.push_back({(i == cnt - 1 && s == WORDS - 1),
                           sample(i, s)});
        end
      end
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    t0      = cyc;
    @(negedge clk);
    start_i = 1'b0;
    check("busy_after_start", busy_o, 1);
  endtask

  task automatic wait_done(output int l);
    l = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_o) begin
        l = cyc - t0;
        break;
      end
    end
    check("done_seen", (l >= 0), 1);
  endtask

  task automatic finish_run(input int cnt);
    repeat (3) @(negedge clk);
    check("beats_left", exp_q.size(), 0);
    check("beat_count", got_q.size(), cnt * WORDS);
    check("done_pulses", n_done, 1);
    check("busy_idle", busy_o, 0);
    check("count_o", count_o, cnt);
    check("idx_writes", idx_log.size(), cnt);
    foreach (idx_log[k]) check("idx_order", idx_log[k], k);
    check("sel_writes", sel_log.size(), cnt * WORDS);
    foreach (sel_log[k]) check("sel_seq", sel_log[k], k % WORDS);
  endtask

  task automatic check_quiet(input string nm);
    check({nm, "_ctl"}, {busy_o, done_o, tvalid_o, tlast_o, iob_valid_o},
          0);
    check({nm, "_cnt"}, count_o, 0);
    check({nm, "_tdata"}, tdata_o, 0);
    check({nm, "_bus"}, {iob_addr_o, iob_wdata_o, iob_wstrb_o}, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst_n_i = 1'b1;
    @(negedge clk);

    // Plain run: three samples, two words each.
    prep(32'd3, 0, 1, 1'b0, 1'b1);
    pulse_start();
    wait_done(lat);
    finish_run(3);
    check("lit_beat0", got_q[0], 32'h0000_00A0);
    check("lit_beat1", got_q[1], 32'h0000_01A0);
    check("lit_beat4", got_q[4], 32'h0000_00A2);
    check("lit_beat5", got_q[5], 32'h0000_01A2);

    // Empty buffer: done within a few cycles, no stream.
    prep(32'd0, 0, 1, 1'b0, 1'b0);
    pulse_start();
    wait_done(lat);
    check("empty_latency_3to5", (lat >= 3 && lat <= 5), 1);
    finish_run(0);

    // Random back-pressure plus a start request mid-run.
    prep(32'd2, 0, 1, 1'b1, 1'b1);
    pulse_start();
    repeat (15) @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(lat);
    finish_run(2);
    check("lit_rnd_beat3", got_q[3], 32'h0000_01A1);

    // Slow slave; upper N_SAMPLES bits must be ignored.
    prep(32'hFFFF_F003, 4, 3, 1'b0, 1'b1);
    pulse_start();
    wait_done(lat);
    finish_run(3);

    // Abort while the sample read is outstanding.
    prep(32'd2, 0, 5, 1'b0, 1'b0);
    pulse_start();
    for (int i = 0; i < 200 && n_data_rd == 0; i++) @(negedge clk);
    check("data_read_seen", n_data_rd, 1);
    @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    wait_done(lat);
    done_c = cyc;
    check("abort_waited_rvalid",
          (data_rv_cyc >= 0 && done_c > data_rv_cyc), 1);
    repeat (3) @(negedge clk);
    check("abort_no_beats", got_q.size(), 0);
    check("abort_done_pulses", n_done, 1);
    check("abort_busy", busy_o, 0);
    check("abort_one_read", n_data_rd, 1);

    // Recovery run after abort.
    prep(32'd2, 0, 1, 1'b0, 1'b1);
    pulse_start();
    wait_done(lat);
    finish_run(2);

    // Reset in the middle of a run.
    prep(32'd3, 0, 1, 1'b0, 1'b1);
    pulse_start();
    repeat (20) @(negedge clk);
    rst_n_i = 1'b0;
    @(negedge clk);
    check_quiet("midreset");
    rst_n_i = 1'b1;
    exp_q.delete();
    @(negedge clk);

    prep(32'd1, 1, 2, 1'b0, 1'b1);
    pulse_start();
    wait_done(lat);
    finish_run(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
